eq_selftest: RTL

Built-in self-test engine for the W-bit equality comparator cores in the comparator library. Drives every operand pair `{a, b}` over `2^(2W)` vectors into a comparator instance, waits a programmable settle time, and checks `aeqb` against the expected `a == b`. Reports pass/fail, an error count and the first failing vector. It is the on-chip counterpart of the simulation benches: the comparator consumes operands, and this block produces them and judges the answer.

---
 rtl/eq_selftest.sv | 110 +++++++++++
 1 files changed

// File: rtl/eq_selftest.sv
// rtl/eq_selftest.sv - exhaustive BIST engine for W-bit equality comparators
// Optional EQ_SELFTEST_STOP_ON_ERR_EN: end the run at the first mismatch.
module eq_selftest #(
   parameter int W      = 2,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [W-1:0]     dut_a,
   output logic [W-1:0]     dut_b,
   input  logic             dut_aeqb,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [W-1:0]     fail_a,
   output logic [W-1:0]     fail_b
);

   localparam int VW = 2 * W;
   localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [VW-1:0]    V_LAST      = '1;
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);

   logic [1:0]    state;
   logic [VW-1:0] v;
   logic [SW-1:0] settle_cnt;
   logic          mismatch;
   logic          stop_now;
   logic          last_vec;

   // Operands come straight from the vector register, so they are registered outputs.
   assign dut_a    = v[VW-1:W];
   assign dut_b    = v[W-1:0];
   assign busy     = (state == ST_APPLY) || (state == ST_CHECK);
   assign done     = (state == ST_DONE);
   assign mismatch = dut_aeqb != (dut_a == dut_b);
   assign last_vec = (v == V_LAST);

`ifdef EQ_SELFTEST_STOP_ON_ERR_EN
   assign stop_now = mismatch;
`else
   assign stop_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         v          <= '0;
         settle_cnt <= '0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_APPLY;
                  v          <= '0;
                  settle_cnt <= '0;
                  pass       <= 1'b0;
                  err_cnt    <= '0;
                  fail_a     <= '0;
                  fail_b     <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_APPLY: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  if (err_cnt != ERR_MAX)
                     err_cnt <= err_cnt + ERR_W'(1);
                  if (err_cnt == '0) begin
                     fail_a <= dut_a;
                     fail_b <= dut_b;
                  end
               end
               // pass is resolved on entry to DONE so it is already final there.
               if (last_vec || stop_now) begin
                  state <= ST_DONE;
                  pass  <= !mismatch && (err_cnt == '0);
               end else begin
                  v     <= v + VW'(1);
                  state <= ST_APPLY;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
